// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the LOAD/STORE memory path: responder FSM encoding
// and the core opcodes that produce req_valid / req_write.
`timescale 1ns/1ps
package cpu_defs;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic [3:0] LOAD = 4'b1000;
  localparam logic [3:0] STOR = 4'b1001;

  function automatic logic is_mem_op(input logic [3:0] opcode);
    return (opcode == LOAD) || (opcode == STOR);
  endfunction

endpackage

// File: rtl/data_mem_responder_word_ram.sv
// DEPTH x 16 word array: synchronous write, combinational read.
`timescale 1ns/1ps
module word_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: accepts one word request, waits WAIT_CYCLES in BUSY,
// performs the RAM access and returns a single-cycle response.
`timescale 1ns/1ps
module data_mem_responder
  import cpu_defs::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        stall,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic [7:0]  err_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic        write_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        accept;
  logic        access;
  logic        addr_err;
  logic        ram_we;
  logic [15:0] ram_rdata;

  assign addr_err = addr_q[0] | ({17'd0, addr_q[15:1]} >= 32'(DEPTH));
  // A reset landing on the access edge must drop the store entirely.
  assign ram_we   = access && write_q && !addr_err && !reset;

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    stall      = 1'b0;
    accept     = 1'b0;
    access     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !reset;
        stall     = req_valid;
        if (req_valid && !reset) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == 4'd0) begin
          access     = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= 4'd0;
      write_q    <= 1'b0;
      addr_q     <= 16'd0;
      wdata_q    <= 16'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 16'd0;
      resp_err   <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      resp_valid <= access;
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= CNT_INIT;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        resp_err   <= addr_err;
        resp_rdata <= (addr_err || write_q) ? 16'd0 : ram_rdata;
        if (addr_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

  word_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_word_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(addr_q[AW:1]),
    .wdata(wdata_q),
    .raddr(addr_q[AW:1]),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one default build and one
// WAIT_CYCLES=1 build sharing request inputs, selected by targetW1.
`timescale 1ns/1ps
module tb_data_mem_responder;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqWrite;
  logic [15:0] reqAddr;
  logic [15:0] reqWdata;
  bit          targetW1;

  logic        reqReady0, stall0, respValid0, respErr0;
  logic [15:0] respRdata0;
  logic [7:0]  errCount0;
  logic        reqReady1, stall1, respValid1, respErr1;
  logic [15:0] respRdata1;
  logic [7:0]  errCount1;

  logic        reqReady, stall, respValid, respErr;
  logic [15:0] respRdata;
  logic [7:0]  errCount;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (reqValid && !targetW1),
    .req_write (reqWrite),
    .req_addr  (reqAddr),
    .req_wdata (reqWdata),
    .req_ready (reqReady0),
    .stall     (stall0),
    .resp_valid(respValid0),
    .resp_rdata(respRdata0),
    .resp_err  (respErr0),
    .err_count (errCount0)
  );

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(1)) dutW1 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (reqValid && targetW1),
    .req_write (reqWrite),
    .req_addr  (reqAddr),
    .req_wdata (reqWdata),
    .req_ready (reqReady1),
    .stall     (stall1),
    .resp_valid(respValid1),
    .resp_rdata(respRdata1),
    .resp_err  (respErr1),
    .err_count (errCount1)
  );

  assign reqReady  = targetW1 ? reqReady1  : reqReady0;
  assign stall     = targetW1 ? stall1     : stall0;
  assign respValid = targetW1 ? respValid1 : respValid0;
  assign respErr   = targetW1 ? respErr1   : respErr0;
  assign respRdata = targetW1 ? respRdata1 : respRdata0;
  assign errCount  = targetW1 ? errCount1  : errCount0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Issues one request, then waits (bounded) for the response pulse.
  // lat is counted in cycles from the accept cycle; 0 means no response.
  task automatic applyStimulus(input logic [3:0] opcode, input logic [15:0] addr,
                               input logic [15:0] wdata, output logic [15:0] rdata,
                               output logic err, output int lat);
    @(posedge clk); #1;
    reqValid = is_mem_op(opcode);
    reqWrite = (opcode == STOR);
    reqAddr  = addr;
    reqWdata = wdata;
    @(posedge clk); #1;
    reqValid = 1'b0;
    reqWrite = 1'b0;
    reqAddr  = 16'd0;
    reqWdata = 16'd0;
    lat   = 0;
    rdata = 16'hxxxx;
    err   = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (respValid === 1'b1) begin
        lat   = i;
        rdata = respRdata;
        err   = respErr;
        break;
      end
    end
  endtask

  // Holds req_valid high for two full access periods and checks the
  // stall/ready/resp pattern cycle by cycle against the period model.
  task automatic checkBackToBack(input int waitCycles, input logic [15:0] addr,
                                 input logic [15:0] expData);
    int period;
    int p;
    period = waitCycles + 2;
    @(posedge clk); #1;
    reqValid = 1'b1;
    reqWrite = 1'b0;
    reqAddr  = addr;
    for (int i = 0; i < 2 * period; i++) begin
      p = i % period;
      @(negedge clk);
      checkOutput($sformatf("b2b_w%0d_stall_c%0d", waitCycles, i), 32'(stall), 32'(p <= waitCycles));
      checkOutput($sformatf("b2b_w%0d_ready_c%0d", waitCycles, i), 32'(reqReady), 32'(p == 0));
      checkOutput($sformatf("b2b_w%0d_resp_c%0d", waitCycles, i), 32'(respValid), 32'(p == waitCycles + 1));
      if (p == waitCycles + 1)
        checkOutput($sformatf("b2b_w%0d_rdata_c%0d", waitCycles, i), 32'(respRdata), 32'(expData));
      @(posedge clk); #1;
    end
    reqValid = 1'b0;
    reqAddr  = 16'd0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] rd;
    logic        er;
    int          lat;
    int          pulses;

    reset    = 1'b1;
    reqValid = 1'b0;
    reqWrite = 1'b0;
    reqAddr  = 16'd0;
    reqWdata = 16'd0;
    targetW1 = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready",     32'(reqReady),  32'd0);
    checkOutput("reset_resp",      32'(respValid), 32'd0);
    checkOutput("reset_rdata",     32'(respRdata), 32'd0);
    checkOutput("reset_err",       32'(respErr),   32'd0);
    checkOutput("reset_err_count", 32'(errCount),  32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_ready", 32'(reqReady), 32'd1);
    checkOutput("post_reset_stall", 32'(stall),    32'd0);

    applyStimulus(STOR, 16'h0010, 16'hCAFE, rd, er, lat);
    checkOutput("store_lat",   32'(lat), 32'd3);
    checkOutput("store_err",   32'(er),  32'd0);
    checkOutput("store_rdata", 32'(rd),  32'd0);

    applyStimulus(LOAD, 16'h0010, 16'h0000, rd, er, lat);
    checkOutput("load_lat",   32'(lat), 32'd3);
    checkOutput("load_err",   32'(er),  32'd0);
    checkOutput("load_rdata", 32'(rd),  32'hCAFE);

    applyStimulus(STOR, 16'h0011, 16'h1234, rd, er, lat);
    checkOutput("misalign_err",       32'(er),       32'd1);
    checkOutput("misalign_rdata",     32'(rd),       32'd0);
    checkOutput("misalign_err_count", 32'(errCount), 32'd1);

    applyStimulus(LOAD, 16'h0010, 16'h0000, rd, er, lat);
    checkOutput("after_misalign_rdata", 32'(rd), 32'hCAFE);

    applyStimulus(LOAD, 16'h0200, 16'h0000, rd, er, lat);
    checkOutput("oor_err",       32'(er),       32'd1);
    checkOutput("oor_rdata",     32'(rd),       32'd0);
    checkOutput("oor_err_count", 32'(errCount), 32'd2);

    applyStimulus(STOR, 16'h01FE, 16'h5A5A, rd, er, lat);
    checkOutput("top_store_err", 32'(er), 32'd0);
    applyStimulus(LOAD, 16'h01FE, 16'h0000, rd, er, lat);
    checkOutput("top_load_err",   32'(er), 32'd0);
    checkOutput("top_load_rdata", 32'(rd), 32'h5A5A);

    checkBackToBack(2, 16'h0010, 16'hCAFE);

    applyStimulus(STOR, 16'h0020, 16'h1111, rd, er, lat);
    checkOutput("pre_store_err", 32'(er), 32'd0);

    @(posedge clk); #1;
    reqValid = 1'b1;
    reqWrite = 1'b1;
    reqAddr  = 16'h0020;
    reqWdata = 16'hBEEF;
    @(posedge clk); #1;
    reqValid = 1'b0;
    reqWrite = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midop_busy_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midop_ready",     32'(reqReady), 32'd1);
    checkOutput("midop_err_count", 32'(errCount), 32'd0);
    pulses = (respValid === 1'b1) ? 1 : 0;
    repeat (5) begin
      @(negedge clk);
      if (respValid === 1'b1) pulses++;
    end
    checkOutput("midop_no_resp", 32'(pulses), 32'd0);

    applyStimulus(LOAD, 16'h0020, 16'h0000, rd, er, lat);
    checkOutput("midop_load_rdata", 32'(rd), 32'h1111);

    for (int n = 0; n < 300; n++)
      applyStimulus(LOAD, 16'h0200, 16'h0000, rd, er, lat);
    checkOutput("sat_err_count", 32'(errCount), 32'd255);
    checkOutput("sat_last_err",  32'(er),       32'd1);

    targetW1 = 1'b1;
    applyStimulus(STOR, 16'h0030, 16'hABCD, rd, er, lat);
    checkOutput("w1_store_lat", 32'(lat), 32'd2);
    applyStimulus(LOAD, 16'h0030, 16'h0000, rd, er, lat);
    checkOutput("w1_load_lat",   32'(lat), 32'd2);
    checkOutput("w1_load_rdata", 32'(rd),  32'hABCD);
    checkBackToBack(1, 16'h0030, 16'hABCD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
